// File: rtl/colnorm_sqrd_scheduler_pkg.sv
// Shared definitions for the sorted-QR column-norm scheduler.
// Word widths come from the WL/FWL/COLNORM_WL/COLNORM_FWL macros (defaults below).
// The optional COLNORM_SORT_EN macro enables argmin pivoting.
`ifndef WL
`define WL 16
`endif
`ifndef FWL
`define FWL 12
`endif
`ifndef COLNORM_WL
`define COLNORM_WL 18
`endif
`ifndef COLNORM_FWL
`define COLNORM_FWL 10
`endif

package colnorm_sqrd_scheduler_pkg;
    localparam int WL          = `WL;
    localparam int FWL         = `FWL;
    localparam int COLNORM_WL  = `COLNORM_WL;
    localparam int COLNORM_FWL = `COLNORM_FWL;
    localparam int SHIFT       = FWL - COLNORM_FWL;
    localparam int PROD_W      = 2 * COLNORM_WL;
    localparam int DIFF_W      = PROD_W + 1;
    localparam int NCOL        = 8;
    localparam int NSTEP       = 7;
    localparam int STEP_W      = 3;
    localparam int PERM_W      = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ROW = 3'd3,
        ST_UPDATE   = 3'd4,
        ST_DONE     = 3'd5
    } state_t;
endpackage

// File: rtl/colnorm_argmin.sv
// Combinational pivot search: smallest signed norm among slots start_i..7,
// lowest slot wins a tie. Only built when COLNORM_SORT_EN is defined.
`ifdef COLNORM_SORT_EN
module colnorm_argmin
    import colnorm_sqrd_scheduler_pkg::*;
(
    input  logic [NCOL*COLNORM_WL-1:0] norms_i,
    input  logic [STEP_W-1:0]          start_i,
    output logic [STEP_W-1:0]          min_o
);
    logic signed [COLNORM_WL-1:0] w_norm [NCOL];
    logic signed [COLNORM_WL-1:0] w_best_val;

    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_unpack
            assign w_norm[gi] = norms_i[gi*COLNORM_WL +: COLNORM_WL];
        end
    endgenerate

    // Linear scan; strict less-than keeps the earliest slot on ties
    always_comb begin
        min_o      = start_i;
        w_best_val = w_norm[start_i];
        for (int k = 0; k < NCOL; k++) begin
            if ((STEP_W'(k) > start_i) && (w_norm[k] < w_best_val)) begin
                min_o      = STEP_W'(k);
                w_best_val = w_norm[k];
            end
        end
    end
endmodule
`endif

// File: rtl/colnorm_sqrd_scheduler.sv
// Column-norm sequencer for the sorted QR of the real 8x8 channel: picks a
// pivot per step, offers it to the QR datapath, then downdates the remaining
// norms with the squared R-row entries. COLNORM_SORT_EN selects argmin
// pivoting; without it columns are processed in natural order.
module colnorm_sqrd_scheduler
    import colnorm_sqrd_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [NCOL*COLNORM_WL-1:0] colnorm_init_i,
    output logic                       busy_o,
    output logic                       pivot_valid_o,
    input  logic                       pivot_ready_i,
    output logic [STEP_W-1:0]          pivot_idx_o,
    output logic [STEP_W-1:0]          step_o,
    input  logic                       row_valid_i,
    output logic                       row_ready_o,
    input  logic [(NCOL-1)*WL-1:0]     row_i,
    output logic [NCOL*COLNORM_WL-1:0] colnorm_o,
    output logic [PERM_W-1:0]          perm_o,
    output logic                       done_o
);
    state_t r_state, w_state_next;
    logic   r_busy, r_pivot_valid, r_row_ready, r_done;
    logic   w_busy_next, w_pivot_valid_next, w_row_ready_next, w_done_next;

    logic signed [COLNORM_WL-1:0] r_norm     [NCOL];
    logic signed [COLNORM_WL-1:0] w_norm_upd [NCOL];
    logic [STEP_W-1:0]            r_perm     [NCOL];
    logic [STEP_W-1:0]            r_step, r_pivot_idx, w_pivot;
    logic [(NCOL-1)*WL-1:0]       r_row;
    logic [NCOL*COLNORM_WL-1:0]   w_norm_flat;
    logic                         w_last_step;

    assign w_last_step = (r_step == STEP_W'(NSTEP-1));

    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_flat
            assign w_norm_flat[gi*COLNORM_WL +: COLNORM_WL] = r_norm[gi];
            assign perm_o[gi*STEP_W +: STEP_W]              = r_perm[gi];
        end

        // Slot 0 is always settled before any downdate can reach it
        assign w_norm_upd[0] = r_norm[0];
        for (gi = 1; gi < NCOL; gi++) begin : g_upd
            logic [STEP_W-1:0]            w_ent_idx;
            logic signed [WL-1:0]         w_ent;
            logic signed [COLNORM_WL-1:0] w_h;
            logic signed [PROD_W-1:0]     w_prod, w_sq;
            logic signed [DIFF_W-1:0]     w_diff;
            // Column gi pairs with row entry gi-1-j
            assign w_ent_idx = STEP_W'(gi-1) - r_step;
            assign w_ent     = r_row[32'(w_ent_idx)*WL +: WL];
            assign w_h       = COLNORM_WL'(w_ent >>> SHIFT);
            assign w_prod    = PROD_W'(w_h) * PROD_W'(w_h);
            assign w_sq      = w_prod >>> COLNORM_FWL;
            assign w_diff    = DIFF_W'(r_norm[gi]) - DIFF_W'(w_sq);
            assign w_norm_upd[gi] = (STEP_W'(gi) > r_step)
                                  ? (w_diff[DIFF_W-1] ? '0 : COLNORM_WL'(w_diff))
                                  : r_norm[gi];
        end
    endgenerate

`ifdef COLNORM_SORT_EN
    colnorm_argmin u_argmin (
        .norms_i (w_norm_flat),
        .start_i (r_step),
        .min_o   (w_pivot)
    );
`else
    assign w_pivot = r_step;
`endif

    // Next-state and registered-output decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (start_i) w_state_next = ST_SELECT;
            ST_SELECT:   w_state_next = ST_ISSUE;
            ST_ISSUE:    if (pivot_ready_i) w_state_next = ST_WAIT_ROW;
            ST_WAIT_ROW: if (row_valid_i) w_state_next = ST_UPDATE;
            ST_UPDATE:   w_state_next = w_last_step ? ST_DONE : ST_SELECT;
            ST_DONE:     w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
        w_busy_next        = (w_state_next != ST_IDLE);
        w_pivot_valid_next = (w_state_next == ST_ISSUE);
        w_row_ready_next   = (w_state_next == ST_WAIT_ROW);
        w_done_next        = (w_state_next == ST_DONE);
    end

    // State register and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_pivot_valid <= 1'b0;
            r_row_ready   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_busy        <= w_busy_next;
            r_pivot_valid <= w_pivot_valid_next;
            r_row_ready   <= w_row_ready_next;
            r_done        <= w_done_next;
        end
    end

    // Norm/permutation storage, pivot latch and row capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCOL; k++) begin
                r_norm[k] <= '0;
                r_perm[k] <= STEP_W'(k);
            end
            r_step      <= '0;
            r_pivot_idx <= '0;
            r_row       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        for (int k = 0; k < NCOL; k++) begin
                            r_norm[k] <= colnorm_init_i[k*COLNORM_WL +: COLNORM_WL];
                            r_perm[k] <= STEP_W'(k);
                        end
                        r_step <= '0;
                    end
                end
                ST_SELECT: begin
`ifdef COLNORM_SORT_EN
                    r_norm[r_step]  <= r_norm[w_pivot];
                    r_norm[w_pivot] <= r_norm[r_step];
                    r_perm[r_step]  <= r_perm[w_pivot];
                    r_perm[w_pivot] <= r_perm[r_step];
`endif
                    r_pivot_idx <= r_perm[w_pivot];
                end
                ST_WAIT_ROW: if (row_valid_i) r_row <= row_i;
                ST_UPDATE: begin
                    for (int k = 0; k < NCOL; k++) r_norm[k] <= w_norm_upd[k];
                    if (!w_last_step) r_step <= r_step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign pivot_valid_o = r_pivot_valid;
    assign row_ready_o   = r_row_ready;
    assign done_o        = r_done;
    assign pivot_idx_o   = r_pivot_idx;
    assign step_o        = r_step;
    assign colnorm_o     = w_norm_flat;
endmodule
